wb_collect: RTL and testbench
=============================

Name: wb_collect

Overview:
- Writeback collector on the return path of the execute stage.
- Accepts results (physical rd tag + data) from the four functional-unit slots fed by the operand bypass network.
- Buffers them in per-slot FIFOs and arbitrates round-robin onto two register-file write ports. These ports double as the result/tag broadcast back to the bypass and wakeup logic.

Parameters:
- WIDTH_DATA, 32, result data width.
- WIDTH_REG, 5, physical register tag width (matches bypass WIDTH_REG).
- DEPTH, 2, entries per slot FIFO (power of two, >=2).

Ports:
- i_clk, input, 1, clock, rising edge.
- i_rst, input, 1, synchronous active-high reset.
- i_valid, input, 4, result valid per slot; bit k = slot k.
- i_rd, input, 4*WIDTH_REG, destination tag per slot; slot k at [k*WIDTH_REG +: WIDTH_REG].
- i_data, input, 4*WIDTH_DATA, result per slot; slot k at [k*WIDTH_DATA +: WIDTH_DATA].
- o_ready, output, 4, slot k can accept this cycle.
- o_we0, output, 1, write port 0 enable.
- o_waddr0, output, WIDTH_REG, write port 0 tag.
- o_wdata0, output, WIDTH_DATA, write port 0 data.
- o_we1, output, 1, write port 1 enable.
- o_waddr1, output, WIDTH_REG, write port 1 tag.
- o_wdata1, output, WIDTH_DATA, write port 1 data.

Behaviour:
- Single clock domain i_clk; reset i_rst is synchronous, active-high.
- Reset:
  - All FIFOs are emptied and the round-robin pointer rr (2 bits) is set to 0.
  - o_we0/o_we1 = 0 and o_waddr*/o_wdata* = 0 (registered outputs).
  - o_ready = 4'b0000 while i_rst is high; inputs are ignored during reset.
- Enqueue:
  - Slot k pushes at the clock edge when i_valid[k] & o_ready[k].
  - o_ready[k] = !i_rst & (count[k] < DEPTH), combinational from the registered count.
  - A full FIFO stays not-ready even when it is popped in the same cycle; there is no pass-through.
- Arbitration, combinational each cycle:
  - Scan the slots in order rr, rr+1, rr+2, rr+3 (mod 4).
  - The first non-empty slot goes to port 0; the second non-empty slot goes to port 1.
  - The granted heads are popped at the edge.
- Pointer update:
  - If any slot is granted, rr <= (index of the last granted slot + 1) mod 4.
  - Otherwise rr is unchanged.
- Output register: at the edge, each port loads we = grant valid, and waddr/wdata = the head entry. A port with no grant loads we=0 and holds its previous waddr/wdata.
- Latency:
  - A result accepted at edge t is visible at the head in cycle t+1.
  - It appears on a write port in cycle t+2 at best: 2 cycles minimum.
  - With no contention this holds every cycle, for a throughput of 2 results/cycle.
- Tag 0 (hardwired zero register):
  - An entry with rd == 0 is granted and popped normally, but its port drives we=0.
  - It still consumes the grant slot and advances rr.
- Ordering:
  - Results from the same slot leave in FIFO order.
  - No ordering is guaranteed across slots.
  - Equal rd on both ports in one cycle is not checked; rename guarantees uniqueness.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both operations occur.
- Pointer wrap-around: 3+1 -> 0, 2-bit arithmetic.
- Reset mid-operation: all buffered results are discarded and no write is issued in the cycle after reset.

Optional Feature:
- Macro: WB_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt, 32 bits.
  - The counter increments by 1 every cycle in which at least one non-empty slot is not granted, and saturates at 0xFFFFFFFF.
  - It is cleared by i_rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single result: after reset, slot 2 pushes rd=5, data=0xDEADBEEF at edge t.
  - Required: cycle t+2 shows o_we0=1, o_waddr0=5, o_wdata0=0xDEADBEEF, o_we1=0.
  - Required: rr=3 afterwards.
- Four simultaneous results: slots 0-3 push rd=1..4 at edge t with rr=0.
  - Required: cycle t+2 shows port0 rd1, port1 rd2.
  - Required: cycle t+3 shows port0 rd3, port1 rd4.
  - Required: cycle t+4 shows both we=0.
- Backpressure with DEPTH=2: slot 1 pushes on 3 consecutive cycles while slots 0, 2 and 3 are kept busy.
  - Required: o_ready[1] stays 1 while count<2 and drops to 0 when count=2.
  - Required: the third push is held until o_ready[1]=1; all 3 results appear in order and none is lost or duplicated.
- Tag 0 drop: slot 0 pushes rd=0 and slot 1 pushes rd=7 at edge t.
  - Required: cycle t+2 shows o_we0=0 and o_we1=1 with o_waddr1=7.
- Reset mid-operation: fill all FIFOs, then assert i_rst for 1 cycle.
  - Required: o_ready=0 during reset.
  - Required: no write enables in the following 2 cycles, and o_ready=4'b1111 afterwards.
- WB_STALL_CNT_EN: 4 slots are continuously non-empty for 10 cycles.
  - Required: o_stall_cnt increments by 10; it stays constant once all FIFOs drain.

Source files
------------

// File: rtl/wb_collect.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : wb_collect
//  Function : Writeback collector. Buffers results from four functional-unit
//             slots in per-slot FIFOs and arbitrates them round-robin onto two
//             registered register-file write ports (also the wakeup/bypass
//             broadcast). Tag 0 is granted and popped but never written.
//  Options  : WB_STALL_CNT_EN adds o_stall_cnt, a saturating count of cycles
//             in which some non-empty slot was left without a grant.
//  Revision : 1.0  initial release
// ============================================================================
module wb_collect #(
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_REG  = 5,
    parameter int DEPTH      = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [3:0]                i_valid,
    input  logic [4*WIDTH_REG-1:0]    i_rd,
    input  logic [4*WIDTH_DATA-1:0]   i_data,
    output logic [3:0]                o_ready,
    output logic                      o_we0,
    output logic [WIDTH_REG-1:0]      o_waddr0,
    output logic [WIDTH_DATA-1:0]     o_wdata0,
    output logic                      o_we1,
    output logic [WIDTH_REG-1:0]      o_waddr1,
    output logic [WIDTH_DATA-1:0]     o_wdata1
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]               o_stall_cnt
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_EW = WIDTH_REG + WIDTH_DATA;

    // FIFO storage and bookkeeping; an entry is {tag, data}
    logic [c_EW-1:0]            r_mem_q [4][DEPTH];
    logic [c_EW-1:0]            w_mem_d [4][DEPTH];
    logic [3:0][c_AW-1:0]       r_rptr_q, w_rptr_d;
    logic [3:0][c_AW-1:0]       r_wptr_q, w_wptr_d;
    logic [3:0][c_CW-1:0]       r_cnt_q,  w_cnt_d;
    logic [1:0]                 r_rr_q,   w_rr_d;

    logic [3:0]                 w_push, w_pop, w_nonempty;
    logic                       w_g0_v, w_g1_v;
    logic [1:0]                 w_g0_idx, w_g1_idx, w_slot;
    logic [c_EW-1:0]            w_head0, w_head1;

    logic                       r_we0_q, w_we0_d, r_we1_q, w_we1_d;
    logic [WIDTH_REG-1:0]       r_waddr0_q, w_waddr0_d, r_waddr1_q, w_waddr1_d;
    logic [WIDTH_DATA-1:0]      r_wdata0_q, w_wdata0_d, r_wdata1_q, w_wdata1_d;

    // Per-slot readiness from the registered occupancy; a full FIFO stays
    // not-ready even if it is being popped (no pass-through path)
    always_comb begin
        o_ready    = '0;
        w_nonempty = '0;
        w_push     = '0;
        for (int k = 0; k < 4; k++) begin
            o_ready[k]    = !i_rst && (r_cnt_q[k] < c_CW'(DEPTH));
            w_nonempty[k] = (r_cnt_q[k] != '0);
            w_push[k]     = i_valid[k] && o_ready[k];
        end
    end

    // Round-robin scan from rr: first non-empty slot -> port 0, second -> port 1
    always_comb begin
        w_g0_v   = 1'b0;
        w_g1_v   = 1'b0;
        w_g0_idx = '0;
        w_g1_idx = '0;
        w_slot   = '0;
        for (int i = 0; i < 4; i++) begin
            w_slot = r_rr_q + 2'(i);
            if (w_nonempty[w_slot]) begin
                if (!w_g0_v) begin
                    w_g0_v   = 1'b1;
                    w_g0_idx = w_slot;
                end else if (!w_g1_v) begin
                    w_g1_v   = 1'b1;
                    w_g1_idx = w_slot;
                end
            end
        end
        w_pop = '0;
        for (int k = 0; k < 4; k++) begin
            w_pop[k] = (w_g0_v && (w_g0_idx == 2'(k))) ||
                       (w_g1_v && (w_g1_idx == 2'(k)));
        end
        // Pointer moves just past the last granted slot (2-bit wrap)
        if (w_g1_v) begin
            w_rr_d = w_g1_idx + 2'd1;
        end else if (w_g0_v) begin
            w_rr_d = w_g0_idx + 2'd1;
        end else begin
            w_rr_d = r_rr_q;
        end
    end

    // FIFO next state: write at wptr, read at rptr, occupancy tracks both
    always_comb begin
        w_mem_d  = r_mem_q;
        w_rptr_d = r_rptr_q;
        w_wptr_d = r_wptr_q;
        w_cnt_d  = r_cnt_q;
        for (int k = 0; k < 4; k++) begin
            if (w_push[k]) begin
                w_mem_d[k][r_wptr_q[k]] = {i_rd[k*WIDTH_REG +: WIDTH_REG],
                                           i_data[k*WIDTH_DATA +: WIDTH_DATA]};
                w_wptr_d[k] = r_wptr_q[k] + c_AW'(1);
            end
            if (w_pop[k]) begin
                w_rptr_d[k] = r_rptr_q[k] + c_AW'(1);
            end
            if (w_push[k] && !w_pop[k]) begin
                w_cnt_d[k] = r_cnt_q[k] + c_CW'(1);
            end else if (!w_push[k] && w_pop[k]) begin
                w_cnt_d[k] = r_cnt_q[k] - c_CW'(1);
            end
        end
    end

    // Write-port next state: granted head loads the port, tag 0 suppresses we,
    // an idle port keeps its last address/data
    always_comb begin
        w_head0    = r_mem_q[w_g0_idx][r_rptr_q[w_g0_idx]];
        w_head1    = r_mem_q[w_g1_idx][r_rptr_q[w_g1_idx]];
        w_we0_d    = w_g0_v && (w_head0[c_EW-1 -: WIDTH_REG] != '0);
        w_we1_d    = w_g1_v && (w_head1[c_EW-1 -: WIDTH_REG] != '0);
        w_waddr0_d = w_g0_v ? w_head0[c_EW-1 -: WIDTH_REG] : r_waddr0_q;
        w_wdata0_d = w_g0_v ? w_head0[WIDTH_DATA-1:0]      : r_wdata0_q;
        w_waddr1_d = w_g1_v ? w_head1[c_EW-1 -: WIDTH_REG] : r_waddr1_q;
        w_wdata1_d = w_g1_v ? w_head1[WIDTH_DATA-1:0]      : r_wdata1_q;
    end

    // Entry storage needs no reset; pushes are already blocked during reset
    always_ff @(posedge i_clk) begin
        r_mem_q <= w_mem_d;
    end

    // Control state and registered write ports
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rptr_q   <= '0;
            r_wptr_q   <= '0;
            r_cnt_q    <= '0;
            r_rr_q     <= '0;
            r_we0_q    <= 1'b0;
            r_we1_q    <= 1'b0;
            r_waddr0_q <= '0;
            r_waddr1_q <= '0;
            r_wdata0_q <= '0;
            r_wdata1_q <= '0;
        end else begin
            r_rptr_q   <= w_rptr_d;
            r_wptr_q   <= w_wptr_d;
            r_cnt_q    <= w_cnt_d;
            r_rr_q     <= w_rr_d;
            r_we0_q    <= w_we0_d;
            r_we1_q    <= w_we1_d;
            r_waddr0_q <= w_waddr0_d;
            r_waddr1_q <= w_waddr1_d;
            r_wdata0_q <= w_wdata0_d;
            r_wdata1_q <= w_wdata1_d;
        end
    end

    assign o_we0    = r_we0_q;
    assign o_waddr0 = r_waddr0_q;
    assign o_wdata0 = r_wdata0_q;
    assign o_we1    = r_we1_q;
    assign o_waddr1 = r_waddr1_q;
    assign o_wdata1 = r_wdata1_q;

`ifdef WB_STALL_CNT_EN
    logic [31:0] r_stall_q, w_stall_d;

    // Count cycles where a non-empty slot is left waiting; saturate at max
    always_comb begin
        w_stall_d = r_stall_q;
        if (|(w_nonempty & ~w_pop) && (r_stall_q != '1)) begin
            w_stall_d = r_stall_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_q <= '0;
        end else begin
            r_stall_q <= w_stall_d;
        end
    end

    assign o_stall_cnt = r_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_collect.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_wb_collect
//  Function : Directed bench for wb_collect with a reference model feeding a
//             queue of expected write-port results, plus fixed-value checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_collect;

    localparam int WD  = 32;
    localparam int WR  = 5;
    localparam int DEP = 2;

    typedef struct packed {
        logic [WR-1:0] rd;
        logic [WD-1:0] data;
    } ent_t;

    typedef struct packed {
        logic          we0;
        logic [WR-1:0] a0;
        logic [WD-1:0] d0;
        logic          we1;
        logic [WR-1:0] a1;
        logic [WD-1:0] d1;
        logic [31:0]   stall;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic [3:0]       i_valid = '0;
    logic [4*WR-1:0]  i_rd = '0;
    logic [4*WD-1:0]  i_data = '0;
    logic [3:0]       o_ready;
    logic             o_we0, o_we1;
    logic [WR-1:0]    o_waddr0, o_waddr1;
    logic [WD-1:0]    o_wdata0, o_wdata1;
`ifdef WB_STALL_CNT_EN
    logic [31:0]      o_stall_cnt;
`endif

    wb_collect #(.WIDTH_DATA(WD), .WIDTH_REG(WR), .DEPTH(DEP)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_rd     (i_rd),
        .i_data   (i_data),
        .o_ready  (o_ready),
        .o_we0    (o_we0),
        .o_waddr0 (o_waddr0),
        .o_wdata0 (o_wdata0),
        .o_we1    (o_we1),
        .o_waddr1 (o_waddr1),
        .o_wdata1 (o_wdata1)
`ifdef WB_STALL_CNT_EN
        ,
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int   total = 0;
    int   bad   = 0;
    ent_t mq   [4][$];
    ent_t pend [4][$];
    exp_t exp_q[$];
    exp_t last = '0;
    int   rr_m = 0;
    logic [WR-1:0] seen1[$];
    int   nr1_low = 0;

    function automatic ent_t mk(input logic [WR-1:0] rd, input logic [WD-1:0] d);
        ent_t e;
        e.rd   = rd;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive heads of pending queues, model the cycle, check after edge
    task automatic run_cycle(input logic rst);
        logic [3:0] v, er;
        int g0, g1, ne, gr, s;
        bit g0v, g1v;
        exp_t e;
        ent_t h;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if (pend[k].size() > 0) begin
                v[k] = 1'b1;
                i_rd[k*WR +: WR]   = pend[k][0].rd;
                i_data[k*WD +: WD] = pend[k][0].data;
            end else begin
                i_rd[k*WR +: WR]   = '0;
                i_data[k*WD +: WD] = '0;
            end
        end
        i_rst   = rst;
        i_valid = v;
        #1;
        for (int k = 0; k < 4; k++) er[k] = !rst && (mq[k].size() < DEP);
        chk("ready", 64'(o_ready), 64'(er));
        if (!rst && !o_ready[1] && pend[1].size() > 0) nr1_low++;

        e = last;
        e.we0 = 1'b0;
        e.we1 = 1'b0;
        if (rst) begin
            for (int k = 0; k < 4; k++) mq[k].delete();
            rr_m = 0;
            e = '0;
        end else begin
            g0v = 0; g1v = 0; g0 = 0; g1 = 0; ne = 0;
            for (int i = 0; i < 4; i++) begin
                s = (rr_m + i) % 4;
                if (mq[s].size() > 0) begin
                    ne++;
                    if (!g0v) begin g0v = 1; g0 = s; end
                    else if (!g1v) begin g1v = 1; g1 = s; end
                end
            end
            gr = int'(g0v) + int'(g1v);
            if (ne > gr && e.stall != 32'hFFFF_FFFF) e.stall = e.stall + 32'd1;
            if (g0v) begin
                h = mq[g0].pop_front();
                e.we0 = (h.rd != '0); e.a0 = h.rd; e.d0 = h.data;
            end
            if (g1v) begin
                h = mq[g1].pop_front();
                e.we1 = (h.rd != '0); e.a1 = h.rd; e.d1 = h.data;
            end
            if (g1v) rr_m = (g1 + 1) % 4;
            else if (g0v) rr_m = (g0 + 1) % 4;
            for (int k = 0; k < 4; k++)
                if (v[k] && er[k]) mq[k].push_back(pend[k].pop_front());
        end
        last = e;
        exp_q.push_back(e);

        @(posedge i_clk);
        #1;
        e = exp_q.pop_front();
        chk("we0",    64'(o_we0),    64'(e.we0));
        chk("waddr0", 64'(o_waddr0), 64'(e.a0));
        chk("wdata0", 64'(o_wdata0), 64'(e.d0));
        chk("we1",    64'(o_we1),    64'(e.we1));
        chk("waddr1", 64'(o_waddr1), 64'(e.a1));
        chk("wdata1", 64'(o_wdata1), 64'(e.d1));
`ifdef WB_STALL_CNT_EN
        chk("stall_cnt", 64'(o_stall_cnt), 64'(e.stall));
`endif
        if (o_we0 && o_waddr0 >= 5'd17 && o_waddr0 <= 5'd19) seen1.push_back(o_waddr0);
        if (o_we1 && o_waddr1 >= 5'd17 && o_waddr1 <= 5'd19) seen1.push_back(o_waddr1);
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < 4; k++)
            if (pend[k].size() > 0 || mq[k].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [14:0] order;
        int n;
        // Reset state
        run_cycle(1'b1);
        run_cycle(1'b1);
        chk("rst_we0",   64'(o_we0),    64'd0);
        chk("rst_we1",   64'(o_we1),    64'd0);
        chk("rst_addr0", 64'(o_waddr0), 64'd0);
        chk("rst_data1", 64'(o_wdata1), 64'd0);
        chk("rst_ready", 64'(o_ready),  64'd0);

        // Single result from slot 2
        pend[2].push_back(mk(5'd5, 32'hDEADBEEF));
        run_cycle(1'b0);
        run_cycle(1'b0);
        chk("single_we0",   64'(o_we0),    64'd1);
        chk("single_addr0", 64'(o_waddr0), 64'd5);
        chk("single_data0", 64'(o_wdata0), 64'hDEADBEEF);
        chk("single_we1",   64'(o_we1),    64'd0);

        // rr is now 3: slot 3 must beat slot 0
        pend[3].push_back(mk(5'd9, 32'h9999_0003));
        pend[0].push_back(mk(5'd8, 32'h8888_0000));
        run_cycle(1'b0);
        run_cycle(1'b0);
        chk("rr3_addr0", 64'(o_waddr0), 64'd9);
        chk("rr3_addr1", 64'(o_waddr1), 64'd8);

        // Four simultaneous results with rr = 0
        run_cycle(1'b1);
        for (int k = 0; k < 4; k++) pend[k].push_back(mk(5'(k + 1), 32'h100 + 32'(k)));
        run_cycle(1'b0);
        run_cycle(1'b0);
        chk("four_a0_t2", 64'(o_waddr0), 64'd1);
        chk("four_a1_t2", 64'(o_waddr1), 64'd2);
        chk("four_we_t2", 64'({o_we0, o_we1}), 64'b11);
        run_cycle(1'b0);
        chk("four_a0_t3", 64'(o_waddr0), 64'd3);
        chk("four_a1_t3", 64'(o_waddr1), 64'd4);
        run_cycle(1'b0);
        chk("four_we_t4", 64'({o_we0, o_we1}), 64'b00);

        // Tag 0 drop
        pend[0].push_back(mk(5'd0, 32'h0BAD_0000));
        pend[1].push_back(mk(5'd7, 32'h7777_7777));
        run_cycle(1'b0);
        run_cycle(1'b0);
        chk("tag0_we0",   64'(o_we0),    64'd0);
        chk("tag0_we1",   64'(o_we1),    64'd1);
        chk("tag0_addr1", 64'(o_waddr1), 64'd7);

        // Backpressure on slot 1 while the other slots stay busy
        seen1.delete();
        nr1_low = 0;
        for (int i = 0; i < 3; i++) pend[1].push_back(mk(5'(17 + i), 32'h1100 + 32'(i)));
        for (int i = 0; i < 5; i++) begin
            pend[0].push_back(mk(5'(21 + i), 32'h2000 + 32'(i)));
            pend[2].push_back(mk(5'(26 + i), 32'h3000 + 32'(i)));
            pend[3].push_back(mk(5'(1 + i),  32'h4000 + 32'(i)));
        end
        n = 0;
        while (!all_idle() && n < 60) begin
            run_cycle(1'b0);
            n++;
        end
        run_cycle(1'b0);
        run_cycle(1'b0);
        chk("bp_drained", 64'(all_idle()), 64'd1);
        chk("bp_ready_low", 64'(nr1_low > 0), 64'd1);
        chk("bp_count", 64'(seen1.size()), 64'd3);
        order = '0;
        for (int i = 0; i < seen1.size() && i < 3; i++) order[14 - 5*i -: 5] = seen1[i];
        chk("bp_order", 64'(order), 64'({5'd17, 5'd18, 5'd19}));

        // Reset mid-operation
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) pend[k].push_back(mk(5'(k*4 + i + 1), 32'h5000 + 32'(k*4 + i)));
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_cycle(1'b0);
        run_cycle(1'b1);
        chk("mid_rst_ready", 64'(o_ready), 64'd0);
        for (int k = 0; k < 4; k++) pend[k].delete();
        run_cycle(1'b0);
        chk("mid_we_c1", 64'({o_we0, o_we1}), 64'd0);
        chk("mid_ready_c1", 64'(o_ready), 64'hF);
        run_cycle(1'b0);
        chk("mid_we_c2", 64'({o_we0, o_we1}), 64'd0);
        chk("mid_ready_c2", 64'(o_ready), 64'hF);

`ifdef WB_STALL_CNT_EN
        begin
            logic [31:0] s0, s1;
            run_cycle(1'b1);
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 20; i++) pend[k].push_back(mk(5'(k*5 + 1), 32'h6000 + 32'(i)));
            run_cycle(1'b0);
            run_cycle(1'b0);
            s0 = o_stall_cnt;
            for (int i = 0; i < 10; i++) run_cycle(1'b0);
            chk("stall_delta", 64'(o_stall_cnt - s0), 64'd10);
            for (int k = 0; k < 4; k++) pend[k].delete();
            for (int i = 0; i < 8; i++) run_cycle(1'b0);
            s1 = o_stall_cnt;
            for (int i = 0; i < 3; i++) run_cycle(1'b0);
            chk("stall_hold", 64'(o_stall_cnt), 64'(s1));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
